des_key_schedule: RTL and testbench

Sequential DES/3DES key-schedule generator. Holds a bank of 64-bit keys (one per 3DES stage), applies PC-1 once per run, rotates C/D per round, and streams the sixteen 48-bit round subkeys through PC-2 over a valid/ready handshake. Subkeys are produced in encrypt order (K1..K16) or decrypt order (K16..K1). Sits between the key-load path (ECCDH-derived keys) and the DES round datapath.

---
 rtl/des_pkg.sv | 44 ++++
 rtl/des_key_permutation1.sv | 13 +
 rtl/des_key_permutation2.sv | 13 +
 rtl/des_key_schedule.sv | 117 +++++++++++
 tb/tb_des_key_schedule.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 index tables, shift schedule and FSM states.
// Table entries use DES 1-based bit numbering.
package des_pkg;

  localparam int unsigned KeyW    = 64;
  localparam int unsigned CdW     = 56;
  localparam int unsigned SubkeyW = 48;
  localparam int unsigned HalfW   = 28;
  localparam int unsigned Rounds  = 16;

  localparam int unsigned Pc1Table [CdW] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned Pc2Table [SubkeyW] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  // Entry i is S[i+1]: rotation applied to reach C(i+1)/D(i+1).
  localparam int unsigned ShiftSched [Rounds] = '{
    1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1
  };

  typedef enum logic {StIdle, StEmit} ks_state_e;

  function automatic logic shift_is_two(input logic [3:0] idx);
    return ShiftSched[idx] == 2;
  endfunction

  function automatic logic [0:HalfW-1] rotl28(input logic [0:HalfW-1] h, input logic two);
    return two ? {h[2:HalfW-1], h[0:1]} : {h[1:HalfW-1], h[0]};
  endfunction

  function automatic logic [0:HalfW-1] rotr28(input logic [0:HalfW-1] h, input logic two);
    return two ? {h[HalfW-2:HalfW-1], h[0:HalfW-3]} : {h[HalfW-1], h[0:HalfW-2]};
  endfunction

endpackage

// File: rtl/des_key_permutation1.sv
// DES Permuted Choice 1: drops parity bits and reorders the 64-bit key into C0||D0.
module des_key_permutation1
  import des_pkg::*;
(
  input  logic [0:KeyW-1] key,
  output logic [0:CdW-1]  cd
);

  for (genvar i = 0; i < CdW; i++) begin : g_bit
    assign cd[i] = key[Pc1Table[i] - 1];
  end

endmodule

// File: rtl/des_key_permutation2.sv
// DES Permuted Choice 2: selects the 48 subkey bits from the rotated C||D register.
module des_key_permutation2
  import des_pkg::*;
(
  input  logic [0:CdW-1]     cd,
  output logic [0:SubkeyW-1] subkey
);

  for (genvar i = 0; i < SubkeyW; i++) begin : g_bit
    assign subkey[i] = cd[Pc2Table[i] - 1];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES/3DES key schedule: a bank of PC-1 reduced keys and a C/D rotator that
// streams sixteen PC-2 subkeys in encrypt or decrypt order over a valid/ready handshake.
module des_key_schedule
  import des_pkg::*;
#(
  parameter int unsigned KEY_SLOTS = 3,
  localparam int unsigned SLOT_W = (KEY_SLOTS > 1) ? $clog2(KEY_SLOTS) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              key_load,
  input  logic [SLOT_W-1:0] key_slot,
  input  logic [0:63]       key_in,
  input  logic              start,
  input  logic [SLOT_W-1:0] start_slot,
  input  logic              mode,
  input  logic              abort,
  output logic [0:47]       subkey,
  output logic              subkey_valid,
  input  logic              subkey_ready,
  output logic [3:0]        round,
  output logic              last,
  output logic              busy
);

  logic [0:CdW-1]     pc1_out;
  logic [0:CdW-1]     bank_q [KEY_SLOTS];
  logic [0:CdW-1]     start_cd;
  logic [0:CdW-1]     cd_q;
  logic [0:SubkeyW-1] pc2_out;
  logic [3:0]         round_q;
  logic               mode_q;
  logic               last_int;
  logic               load_ok;
  logic               start_ok;
  ks_state_e          state_q;

  des_key_permutation1 u_pc1 (
    .key (key_in),
    .cd  (pc1_out)
  );

  des_key_permutation2 u_pc2 (
    .cd     (cd_q),
    .subkey (pc2_out)
  );

  assign load_ok  = 32'(key_slot) < KEY_SLOTS;
  assign start_ok = 32'(start_slot) < KEY_SLOTS;

  always_comb begin
    start_cd = '0;
    if (start_ok) start_cd = bank_q[start_slot];
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < KEY_SLOTS; i++) bank_q[i] <= '0;
    end else if (key_load && load_ok) begin
      bank_q[key_slot] <= pc1_out;
    end
  end

  assign last_int = mode_q ? (round_q == 4'd0) : (round_q == 4'd15);

  // C16/D16 equal C0/D0 (total rotation 28), so decrypt starts from the stored key.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= StIdle;
      cd_q    <= '0;
      round_q <= '0;
      mode_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start && start_ok && !abort) begin
            state_q <= StEmit;
            mode_q  <= mode;
            if (mode) begin
              cd_q    <= start_cd;
              round_q <= 4'd15;
            end else begin
              cd_q    <= {rotl28(start_cd[0:HalfW-1], shift_is_two(4'd0)),
                          rotl28(start_cd[HalfW:CdW-1], shift_is_two(4'd0))};
              round_q <= 4'd0;
            end
          end
        end
        StEmit: begin
          if (abort) begin
            state_q <= StIdle;
          end else if (subkey_ready) begin
            if (last_int) begin
              state_q <= StIdle;
            end else if (!mode_q) begin
              round_q <= round_q + 4'd1;
              cd_q    <= {rotl28(cd_q[0:HalfW-1], shift_is_two(round_q + 4'd1)),
                          rotl28(cd_q[HalfW:CdW-1], shift_is_two(round_q + 4'd1))};
            end else begin
              round_q <= round_q - 4'd1;
              cd_q    <= {rotr28(cd_q[0:HalfW-1], shift_is_two(round_q)),
                          rotr28(cd_q[HalfW:CdW-1], shift_is_two(round_q))};
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy         = (state_q == StEmit);
  assign subkey_valid = busy;
  assign subkey       = subkey_valid ? pc2_out : '0;
  assign round        = subkey_valid ? round_q : 4'd0;
  assign last         = subkey_valid & last_int;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the well-known 133457799BBCDFF1 subkey set
// and weak keys whose C or D half is constant, giving constant subkeys.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        key_load;
  logic [1:0]  key_slot;
  logic [0:63] key_in;
  logic        start;
  logic [1:0]  start_slot;
  logic        mode;
  logic        abort;
  logic [0:47] subkey;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [3:0]  round;
  logic        last;
  logic        busy;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] KeyA  = 64'h133457799BBCDFF1;
  localparam logic [63:0] KeyCz = 64'h1F1F1F1F0E0E0E0E;  // C = 0, D = all ones
  localparam logic [63:0] KeyDz = 64'hE0E0E0E0F1F1F1F1;  // C = all ones, D = 0

  localparam logic [47:0] KEnc [16] = '{
    48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
    48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
    48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
    48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
  };

  logic [47:0] exp_tab [16];

  des_key_schedule #(.KEY_SLOTS(3)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .key_load     (key_load),
    .key_slot     (key_slot),
    .key_in       (key_in),
    .start        (start),
    .start_slot   (start_slot),
    .mode         (mode),
    .abort        (abort),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .round        (round),
    .last         (last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [1:0] slot, input logic [63:0] k);
    key_load = 1'b1;
    key_slot = slot;
    key_in   = k;
    tick();
    key_load = 1'b0;
  endtask

  task automatic fill_const(input logic [47:0] v);
    for (int i = 0; i < 16; i++) exp_tab[i] = v;
  endtask

  // Full run with ready held high; exp_tab[r] is the subkey for round index r.
  task automatic run_check(input logic [1:0] slot, input logic m, input bit mid_load,
                           input logic [63:0] mid_key, input string name);
    start_slot   = slot;
    mode         = m;
    subkey_ready = 1'b1;
    start        = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      int r;
      r = m ? 15 - i : i;
      checks++;
      if ({subkey_valid, subkey, round, last} !== {1'b1, exp_tab[r], 4'(r), (i == 15)}) begin
        errors++;
        $display("FAIL %s step %0d: got valid=%b subkey=%h round=%0d last=%b, need subkey=%h round=%0d last=%b",
                 name, i, subkey_valid, subkey, round, last, exp_tab[r], r, (i == 15));
      end
      if (mid_load && i == 3) begin
        key_load = 1'b1;
        key_slot = slot;
        key_in   = mid_key;
      end
      tick();
      key_load = 1'b0;
    end
    checks++;
    if (subkey_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s end: got valid=%b busy=%b, need 0 0", name, subkey_valid, busy);
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0; key_load = 1'b0; key_slot = '0; key_in = '0; start = 1'b0;
    start_slot = '0; mode = 1'b0; abort = 1'b0; subkey_ready = 1'b0;
    #3;
    checks++;
    if ({subkey_valid, busy, subkey, round, last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b subkey=%h round=%0d last=%b, need all 0",
               subkey_valid, busy, subkey, round, last);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
  endtask

  task automatic test_encrypt();
    load_key(2'd0, KeyA);
    for (int i = 0; i < 16; i++) exp_tab[i] = KEnc[i];
    run_check(2'd0, 1'b0, 1'b0, '0, "encrypt_slot0");
  endtask

  task automatic test_back_to_back_decrypt();
    // Starts in the first IDLE cycle left by the previous run.
    run_check(2'd0, 1'b1, 1'b0, '0, "decrypt_slot0");
  endtask

  task automatic test_stalls();
    int hs;
    int cyc;
    logic rdy;
    logic [47:0] prev_key;
    logic [3:0]  prev_round;
    logic        prev_last;
    logic        stalled;
    start_slot = 2'd0;
    mode       = 1'b0;
    start      = 1'b1;
    tick();
    hs = 0;
    cyc = 0;
    stalled = 1'b0;
    prev_key = '0; prev_round = '0; prev_last = 1'b0;
    while (hs < 16 && cyc < 200) begin
      rdy = ($urandom_range(0, 2) != 0);
      subkey_ready = rdy;
      start_slot   = 2'd1;  // start held during EMIT must be ignored
      checks++;
      if ({subkey_valid, subkey, round, last} !== {1'b1, KEnc[hs], 4'(hs), (hs == 15)}) begin
        errors++;
        $display("FAIL stall_seq hs %0d: got valid=%b subkey=%h round=%0d last=%b, need %h %0d %b",
                 hs, subkey_valid, subkey, round, last, KEnc[hs], hs, (hs == 15));
      end
      if (stalled) begin
        checks++;
        if ({subkey, round, last} !== {prev_key, prev_round, prev_last}) begin
          errors++;
          $display("FAIL stall_hold: got %h %0d %b, need %h %0d %b",
                   subkey, round, last, prev_key, prev_round, prev_last);
        end
      end
      prev_key = subkey; prev_round = round; prev_last = last;
      stalled = !rdy;
      tick();
      if (rdy) hs++;
      cyc++;
    end
    start = 1'b0;
    subkey_ready = 1'b1;
    checks++;
    if (hs != 16 || subkey_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_count: got handshakes=%0d valid=%b, need 16 0", hs, subkey_valid);
    end
    tick();
  endtask

  task automatic test_slots();
    load_key(2'd1, KeyCz);
    load_key(2'd2, KeyDz);
    fill_const(48'h000000FFFFFF);
    run_check(2'd1, 1'b0, 1'b1, KeyA, "slot1_enc_midload");
    for (int i = 0; i < 16; i++) exp_tab[i] = KEnc[i];
    run_check(2'd1, 1'b1, 1'b0, '0, "slot1_dec_newkey");
    fill_const(48'hFFFFFF000000);
    run_check(2'd2, 1'b0, 1'b0, '0, "slot2_enc");
    run_check(2'd2, 1'b1, 1'b0, '0, "slot2_dec");
    load_key(2'd0, 64'h0101010101010101);  // parity bits only
    fill_const(48'h0);
    run_check(2'd0, 1'b0, 1'b0, '0, "slot0_parity_only");
  endtask

  task automatic test_abort();
    load_key(2'd0, KeyA);
    start_slot = 2'd0; mode = 1'b0; subkey_ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    checks++;
    if ({subkey_valid, subkey, round} !== {1'b1, KEnc[5], 4'd5}) begin
      errors++;
      $display("FAIL abort_pre: got valid=%b subkey=%h round=%0d, need 1 %h 5",
               subkey_valid, subkey, round, KEnc[5]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if ({subkey_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_drop: got valid=%b busy=%b, need 0 0", subkey_valid, busy);
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_beats_start: got busy=%b, need 0", busy);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({subkey_valid, subkey, round} !== {1'b1, KEnc[0], 4'd0}) begin
      errors++;
      $display("FAIL abort_restart: got valid=%b subkey=%h round=%0d, need 1 %h 0",
               subkey_valid, subkey, round, KEnc[0]);
    end
    tick();
  endtask

  task automatic test_reset_midrun();
    // Enters mid-run (round 1 presented) from test_abort.
    #2;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({subkey_valid, busy, subkey} !== '0) begin
      errors++;
      $display("FAIL reset_midrun: got valid=%b busy=%b subkey=%h, need 0 0 0",
               subkey_valid, busy, subkey);
    end
    @(negedge clk);
    n_rst = 1'b1;
    start_slot = 2'd0; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({subkey_valid, subkey, round} !== {1'b1, 48'h0, 4'd0}) begin
      errors++;
      $display("FAIL reset_bank_clear: got valid=%b subkey=%h round=%0d, need 1 0 0",
               subkey_valid, subkey, round);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  task automatic test_same_cycle_and_bad_slot();
    load_key(2'd2, KeyDz);
    key_load = 1'b1; key_slot = 2'd2; key_in = KeyA;
    start = 1'b1; start_slot = 2'd2; mode = 1'b0; subkey_ready = 1'b0;
    tick();
    key_load = 1'b0; start = 1'b0;
    checks++;
    if ({subkey_valid, subkey} !== {1'b1, 48'hFFFFFF000000}) begin
      errors++;
      $display("FAIL same_cycle_old_key: got valid=%b subkey=%h, need 1 ffffff000000",
               subkey_valid, subkey);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({subkey_valid, subkey} !== {1'b1, KEnc[0]}) begin
      errors++;
      $display("FAIL same_cycle_new_key: got valid=%b subkey=%h, need 1 %h",
               subkey_valid, subkey, KEnc[0]);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    start = 1'b1; start_slot = 2'd3;
    tick();
    start = 1'b0;
    checks++;
    if ({subkey_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL bad_slot: got valid=%b busy=%b, need 0 0", subkey_valid, busy);
    end
  endtask

  initial begin
    test_reset();
    test_encrypt();
    test_back_to_back_decrypt();
    test_stalls();
    test_slots();
    test_abort();
    test_reset_midrun();
    test_same_cycle_and_bad_slot();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
